// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and defaults (receiver state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchroniser for a single asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 16x-oversampling UART receiver, 2-of-3 majority per bit,
//               optional odd parity, one-clock valid pulse with error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 os_tick,
    input  logic                 rx_pin,
    input  logic                 parity_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     os_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] word;
    logic                 samp_a;
    logic                 samp_b;
    logic                 par_en;
    logic                 parity_ok;
    logic                 decide;
    logic                 wrap;
    logic                 maj;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (rx_pin),
        .q     (rx_s)
    );

    // Third sample is the live synchronised line at the decision tick.
    assign decide = (os_cnt == CNT_MID + 1'b1);
    assign wrap   = (os_cnt == CNT_LAST);
    assign maj    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RX_IDLE;
            os_cnt        <= '0;
            bit_idx       <= '0;
            word          <= '0;
            samp_a        <= 1'b1;
            samp_b        <= 1'b1;
            par_en        <= 1'b0;
            parity_ok     <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (os_tick) begin
                if (state != RX_IDLE && state != RX_BREAK) begin
                    os_cnt <= wrap ? '0 : os_cnt + 1'b1;
                    if (os_cnt == CNT_MID - 1'b1) samp_a <= rx_s;
                    if (os_cnt == CNT_MID)        samp_b <= rx_s;
                end
                case (state)
                    RX_IDLE: begin
                        if (!rx_s) begin
                            state   <= RX_START;
                            os_cnt  <= '0;
                            rx_busy <= 1'b1;
                            par_en  <= parity_enable;
                        end
                    end
                    RX_START: begin
                        if (decide && maj) begin
                            state   <= RX_IDLE;
                            os_cnt  <= '0;
                            rx_busy <= 1'b0;
                        end else if (wrap) begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end
                    RX_DATA: begin
                        if (decide) word[bit_idx] <= maj;
                        if (wrap) begin
                            if (bit_idx == IDX_LAST) begin
                                state <= par_en ? RX_PARITY : RX_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (decide) parity_ok <= (maj == ~^word);
                        if (wrap)   state     <= RX_STOP;
                    end
                    RX_STOP: begin
                        // Complete mid-stop-bit so a following start edge is not missed.
                        if (decide) begin
                            rx_data       <= word;
                            rx_parity_err <= par_en & ~parity_ok;
                            rx_frame_err  <= ~maj;
                            rx_valid      <= 1'b1;
                            rx_busy       <= 1'b0;
                            os_cnt        <= '0;
                            state         <= maj ? RX_IDLE : RX_BREAK;
                        end
                    end
                    RX_BREAK: begin
                        if (rx_s) state <= RX_IDLE;
                    end
                    default: begin
                        state   <= RX_IDLE;
                        os_cnt  <= '0;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (16x, 4 clk/os_tick).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       os_tick = 1'b0;
    logic       rx_pin;
    logic       parity_enable;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int div     = 0;
    int valid_cnt = 0;
    logic [7:0] cap_data [0:63];
    logic       cap_pe   [0:63];
    logic       cap_fe   [0:63];

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .os_tick       (os_tick),
        .rx_pin        (rx_pin),
        .parity_enable (parity_enable),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div     = (div == 3) ? 0 : div + 1;
        os_tick = (div == 0);
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            cap_data[valid_cnt[5:0]] = rx_data;
            cap_pe[valid_cnt[5:0]]   = rx_parity_err;
            cap_fe[valid_cnt[5:0]]   = rx_frame_err;
            valid_cnt                = valid_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        rx_pin = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_pin = 1'b1;
        repeat (BIT_CLKS * n) @(negedge clk);
    endtask

    // glitch_bit selects a data bit that gets a one-tick low pulse at tick 7.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic par_bad,
                              input logic stop_v, input int glitch_bit);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit && d[i]) begin
                rx_pin = 1'b1;
                repeat (28) @(negedge clk);
                rx_pin = 1'b0;
                repeat (4) @(negedge clk);
                rx_pin = 1'b1;
                repeat (32) @(negedge clk);
            end else begin
                bit_out(d[i]);
            end
        end
        if (par) bit_out((~^d) ^ par_bad);
        bit_out(stop_v);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] d,
                               input logic pe, input logic fe);
        check({tag, " count"}, valid_cnt, base + 1);
        check({tag, " data"},  cap_data[base[5:0]], d);
        check({tag, " perr"},  cap_pe[base[5:0]], pe);
        check({tag, " ferr"},  cap_fe[base[5:0]], fe);
        check({tag, " busy"},  rx_busy, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        reset         = 1'b1;
        rx_pin        = 1'b1;
        parity_enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst data",  rx_data, 8'h00);
        check("rst valid", rx_valid, 1'b0);
        check("rst perr",  rx_parity_err, 1'b0);
        check("rst ferr",  rx_frame_err, 1'b0);
        check("rst busy",  rx_busy, 1'b0);
        reset = 1'b0;
        idle_bits(1);

        base = valid_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(1);
        check_frame("t1 a5", base, 8'hA5, 1'b0, 1'b0);
        check("t1 rx_data hold", rx_data, 8'hA5);

        parity_enable = 1'b1;
        base = valid_cnt;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, -1);
        idle_bits(1);
        check_frame("t2 par ok", base, 8'h03, 1'b0, 1'b0);
        base = valid_cnt;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1);
        idle_bits(1);
        check_frame("t2 par bad", base, 8'h03, 1'b1, 1'b0);
        parity_enable = 1'b0;

        base = valid_cnt;
        rx_pin = 1'b0;
        repeat (20) @(negedge clk);
        check("t3 busy during glitch", rx_busy, 1'b1);
        rx_pin = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("t3 busy after reject", rx_busy, 1'b0);
        check("t3 no valid", valid_cnt, base);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(1);
        check_frame("t3 5a", base, 8'h5A, 1'b0, 1'b0);

        base = valid_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1);
        rx_pin = 1'b0;
        repeat (48 * 4) @(negedge clk);
        check_frame("t4 81", base, 8'h81, 1'b0, 1'b1);
        idle_bits(2);
        check("t4 single pulse", valid_cnt, base + 1);
        base = valid_cnt;
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(1);
        check_frame("t4 42", base, 8'h42, 1'b0, 1'b0);

        base = valid_cnt;
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 3);
        idle_bits(1);
        check("t5 count", valid_cnt, base + 2);
        check("t5 data0", cap_data[base[5:0]], 8'h00);
        check("t5 data1", cap_data[6'(base + 1)], 8'hFF);
        check("t5 flags1", {cap_pe[6'(base + 1)], cap_fe[6'(base + 1)]}, 2'b00);

        base = valid_cnt;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(i[1:0] == 2'd2 || i[1:0] == 2'd3);
        rx_pin = 1'b1;
        repeat (32) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6 rst data",  rx_data, 8'h00);
        check("t6 rst valid", rx_valid, 1'b0);
        check("t6 rst busy",  rx_busy, 1'b0);
        check("t6 rst flags", {rx_parity_err, rx_frame_err}, 2'b00);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        idle_bits(2);
        check("t6 no valid", valid_cnt, base);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(1);
        check_frame("t6 c3", base, 8'hC3, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
